// File: rtl/scan_cmd_engine.sv
// UART byte-command engine driving the scan chain, clock, reset and primary I/O
// of a scan-testable DUT.
module scan_cmd_engine #(
  parameter int CHAIN_LEN = 1919,
  parameter int NIN       = 8,
  parameter int NOUT      = 8,
  parameter int CNT_W     = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  input  logic            tx_ready,
  output logic            tx_start,
  output logic [7:0]      tx_data,
  output logic            busy_o,
  output logic            dut_clk_o,
  output logic            dut_rstn_o,
  output logic            dut_se_o,
  output logic            dut_tm_o,
  output logic            dut_si_o,
  input  logic            dut_so_i,
  output logic [NIN-1:0]  dut_in_o,
  input  logic [NOUT-1:0] dut_out_i
);

  localparam int IB  = (NIN + 7) / 8;
  localparam int OB  = (NOUT + 7) / 8;
  localparam int CB  = CNT_W / 8;
  localparam int BCW = $clog2(CHAIN_LEN + 1);

  localparam logic [7:0] CMD_R = 8'h72;
  localparam logic [7:0] CMD_T = 8'h74;
  localparam logic [7:0] CMD_S = 8'h73;
  localparam logic [7:0] CMD_G = 8'h67;
  localparam logic [7:0] CMD_E = 8'h65;
  localparam logic [7:0] CMD_I = 8'h69;
  localparam logic [7:0] CMD_O = 8'h6F;
  localparam logic [7:0] REP_K = 8'h4B;
  localparam logic [7:0] REP_Q = 8'h3F;

  localparam logic [3:0]     CB_LAST = 4'(CB - 1);
  localparam logic [3:0]     IB_LAST = 4'(IB - 1);
  localparam logic [3:0]     OB_N    = 4'(OB);
  localparam logic [BCW-1:0] CL      = BCW'(CHAIN_LEN);

  typedef enum logic [2:0] {IDLE, ARG, SHIFT, RUN, RSTP, TX, TXW} state_t;
  // A pulse is P_L then P_H; P_SET and P_END are the scan-enable lead/trail cycles.
  typedef enum logic [1:0] {P_SET, P_L, P_H, P_END} phase_t;

  state_t            state;
  phase_t            ph;
  logic [7:0]        cmd;
  logic [3:0]        byte_cnt;
  logic [BCW-1:0]    bit_cnt;
  logic [2:0]        sub;
  logic [7:0]        sh;
  logic [CNT_W-1:0]  run_n;
  logic [CNT_W-1:0]  run_cnt;
  logic [IB*8-1:0]   in_buf;
  logic [OB*8-1:0]   out_buf;

  logic [IB*8-1:0]   in_next;
  logic [CNT_W-1:0]  run_next;
  logic [OB*8-1:0]   out_ext;

  assign busy_o = (state != IDLE);

  // Argument byte placement (LSB byte first) and zero-extended output snapshot.
  always_comb begin
    in_next  = in_buf | ((IB*8)'(rx_data) << {byte_cnt, 3'b000});
    run_next = run_n  | (CNT_W'(rx_data) << {byte_cnt, 3'b000});
    out_ext  = (OB*8)'(dut_out_i);
  end

  // Command FSM with all DUT-facing and UART-facing outputs registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      ph         <= P_SET;
      cmd        <= 8'd0;
      byte_cnt   <= 4'd0;
      bit_cnt    <= '0;
      sub        <= 3'd0;
      sh         <= 8'd0;
      run_n      <= '0;
      run_cnt    <= '0;
      in_buf     <= '0;
      out_buf    <= '0;
      tx_start   <= 1'b0;
      tx_data    <= 8'd0;
      dut_clk_o  <= 1'b0;
      dut_rstn_o <= 1'b0;
      dut_se_o   <= 1'b0;
      dut_tm_o   <= 1'b0;
      dut_si_o   <= 1'b0;
      dut_in_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_start   <= 1'b0;
          dut_rstn_o <= 1'b1;
          if (rx_valid) begin
            cmd      <= rx_data;
            byte_cnt <= 4'd0;
            case (rx_data)
              CMD_R: begin
                dut_rstn_o <= 1'b0;
                run_cnt    <= '0;
                state      <= RSTP;
              end
              CMD_T: state <= ARG;
              CMD_E: begin
                run_n <= '0;
                state <= ARG;
              end
              CMD_I: begin
                in_buf <= '0;
                state  <= ARG;
              end
              CMD_S: begin
                bit_cnt <= '0;
                sub     <= 3'd0;
                state   <= ARG;
              end
              CMD_G: begin
                bit_cnt  <= '0;
                sub      <= 3'd0;
                sh       <= 8'd0;
                dut_se_o <= 1'b1;
                ph       <= P_SET;
                state    <= SHIFT;
              end
              CMD_O: begin
                tx_data  <= out_ext[7:0];
                out_buf  <= out_ext >> 8;
                byte_cnt <= 4'd1;
                state    <= TX;
              end
              default: begin
                tx_data <= REP_Q;
                state   <= TX;
              end
            endcase
          end
        end

        ARG: begin
          if (rx_valid) begin
            case (cmd)
              CMD_T: begin
                dut_tm_o <= rx_data[0];
                tx_data  <= REP_K;
                state    <= TX;
              end
              CMD_E: begin
                run_n    <= run_next;
                byte_cnt <= byte_cnt + 4'd1;
                if (byte_cnt == CB_LAST) begin
                  run_cnt <= '0;
                  ph      <= P_SET;
                  state   <= RUN;
                end
              end
              CMD_I: begin
                in_buf   <= in_next;
                byte_cnt <= byte_cnt + 4'd1;
                if (byte_cnt == IB_LAST) begin
                  dut_in_o <= in_next[NIN-1:0];
                  tx_data  <= REP_K;
                  state    <= TX;
                end
              end
              CMD_S: begin
                sh       <= rx_data;
                sub      <= 3'd0;
                dut_se_o <= 1'b1;
                ph       <= P_SET;
                state    <= SHIFT;
              end
              default: state <= IDLE;
            endcase
          end
        end

        SHIFT: begin
          case (ph)
            P_SET: begin
              dut_si_o <= (cmd == CMD_G) ? dut_so_i : sh[sub];
              ph       <= P_L;
            end
            P_L: begin
              dut_clk_o <= 1'b1;
              bit_cnt   <= bit_cnt + BCW'(1);
              if (cmd == CMD_G) begin
                sh[sub] <= dut_so_i;
              end
              ph <= P_H;
            end
            P_H: begin
              dut_clk_o <= 1'b0;
              if (bit_cnt == CL) begin
                ph <= P_END;
              end else if (sub != 3'd7) begin
                sub      <= sub + 3'd1;
                dut_si_o <= (cmd == CMD_G) ? dut_so_i : sh[sub + 3'd1];
                ph       <= P_L;
              end else begin
                sub <= 3'd0;
                if (cmd == CMD_G) begin
                  tx_data <= sh;
                  state   <= TX;
                end else begin
                  state <= ARG;
                end
              end
            end
            P_END: begin
              dut_se_o <= 1'b0;
              tx_data  <= (cmd == CMD_G) ? sh : REP_K;
              state    <= TX;
            end
            default: state <= IDLE;
          endcase
        end

        RUN: begin
          case (ph)
            P_SET: begin
              if (run_n == '0) begin
                tx_data <= REP_K;
                state   <= TX;
              end else begin
                ph <= P_L;
              end
            end
            P_L: begin
              dut_clk_o <= 1'b1;
              ph        <= P_H;
            end
            P_H: begin
              dut_clk_o <= 1'b0;
              if (run_cnt == run_n - CNT_W'(1)) begin
                tx_data <= REP_K;
                state   <= TX;
              end else begin
                run_cnt <= run_cnt + CNT_W'(1);
                ph      <= P_L;
              end
            end
            default: state <= IDLE;
          endcase
        end

        RSTP: begin
          if (run_cnt == CNT_W'(3)) begin
            dut_rstn_o <= 1'b1;
            tx_data    <= REP_K;
            state      <= TX;
          end else begin
            run_cnt <= run_cnt + CNT_W'(1);
          end
        end

        TX: begin
          if (tx_ready) begin
            tx_start <= 1'b1;
            state    <= TXW;
          end
        end

        // Wait for the UART to accept the byte before sending more or resuming.
        TXW: begin
          tx_start <= 1'b0;
          if (!tx_ready) begin
            if (cmd == CMD_O && byte_cnt != OB_N) begin
              tx_data  <= out_buf[7:0];
              out_buf  <= out_buf >> 8;
              byte_cnt <= byte_cnt + 4'd1;
              state    <= TX;
            end else if (cmd == CMD_G && bit_cnt != CL) begin
              sh    <= 8'd0;
              ph    <= P_SET;
              state <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_cmd_engine.sv
// Randomized scoreboard bench for scan_cmd_engine with a 12-bit scan chain model.
module tb_scan_cmd_engine;
  localparam int CL = 12;
  localparam int NI = 8;
  localparam int NO = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          tx_ready = 1'b1;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          busy_o;
  logic          dut_clk_o, dut_rstn_o, dut_se_o, dut_tm_o, dut_si_o, dut_so_i;
  logic [NI-1:0] dut_in_o;
  logic [NO-1:0] dut_out_i = '0;

  logic [CL-1:0] chain;
  logic [CL-1:0] ref_chain = '0;
  logic [7:0]    exp_q[$];
  logic          si_q[$];
  int            pulses, se_hi, rstn_low;
  int            checks = 0;
  int            fails = 0;

  scan_cmd_engine #(.CHAIN_LEN(CL), .NIN(NI), .NOUT(NO), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data), .busy_o(busy_o),
    .dut_clk_o(dut_clk_o), .dut_rstn_o(dut_rstn_o), .dut_se_o(dut_se_o),
    .dut_tm_o(dut_tm_o), .dut_si_o(dut_si_o), .dut_so_i(dut_so_i),
    .dut_in_o(dut_in_o), .dut_out_i(dut_out_i)
  );

  always #5 clk = ~clk;
  assign dut_so_i = chain[0];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scan chain: shifts toward bit 0 on each DUT clock rise while scan-enabled.
  initial begin
    chain = '0; pulses = 0; se_hi = 0;
    forever begin
      @(posedge dut_clk_o);
      pulses++;
      si_q.push_back(dut_si_o);
      if (dut_se_o) begin
        se_hi++;
        chain = {dut_si_o, chain[CL-1:1]};
      end
    end
  end

  // UART transmitter model and scoreboard consumer.
  initial begin
    int hold;
    logic [7:0] e;
    hold = 0; rstn_low = 0;
    forever begin
      @(negedge clk);
      if (rstn && !dut_rstn_o) rstn_low++;
      if (tx_start) begin
        check("tx_ready_at_start", tx_ready, 1);
        if (exp_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL tx_unexpected: got byte 0x%0h, expected none", tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", tx_data, e);
        end
        tx_ready = 1'b0;
        hold = 4;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) tx_ready = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b, input int gap);
    @(negedge clk); rx_data = b; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy_o || exp_q.size() != 0) && n < budget) begin
      @(negedge clk); n++;
    end
    if (n >= budget) begin
      checks++; fails++;
      $display("FAIL timeout: waited %0d cycles, expected idle within %0d", n, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] b0, input logic [7:0] b1);
    int p0, s0;
    logic [CL-1:0] v, got;
    v = CL'({b1, b0});
    p0 = pulses; s0 = se_hi;
    exp_q.push_back(8'h4B);
    send(8'h73, 2); send(b0, 30); send(b1, 0);
    wait_idle(300);
    check("s_pulses", pulses - p0, CL);
    check("s_se_pulses", se_hi - s0, CL);
    for (int k = 0; k < CL; k++) got[k] = (p0 + k < si_q.size()) ? si_q[p0 + k] : 1'bx;
    check("s_si_seq", got, v);
    check("s_chain", chain, v);
    ref_chain = v;
  endtask

  task automatic do_get();
    int p0, s0;
    p0 = pulses; s0 = se_hi;
    exp_q.push_back(ref_chain[7:0]);
    exp_q.push_back({4'h0, ref_chain[11:8]});
    send(8'h67, 0);
    wait_idle(300);
    check("g_pulses", pulses - p0, CL);
    check("g_se_pulses", se_hi - s0, CL);
    check("g_chain_kept", chain, ref_chain);
  endtask

  task automatic do_run(input logic [15:0] n);
    int p0, s0;
    p0 = pulses; s0 = se_hi;
    exp_q.push_back(8'h4B);
    send(8'h65, 2); send(n[7:0], 2); send(n[15:8], 0);
    wait_idle(2 * int'(n) + 100);
    check("e_pulses", pulses - p0, n);
    check("e_se_low", se_hi - s0, 0);
    check("e_chain_kept", chain, ref_chain);
  endtask

  task automatic do_in(input logic [7:0] v);
    exp_q.push_back(8'h4B);
    send(8'h69, 2); send(v, 0);
    wait_idle(100);
    check("i_dut_in", dut_in_o, v);
  endtask

  task automatic do_out(input logic [7:0] v);
    dut_out_i = v;
    exp_q.push_back(v);
    send(8'h6F, 0);
    wait_idle(100);
  endtask

  task automatic do_tm(input logic [7:0] b);
    exp_q.push_back(8'h4B);
    send(8'h74, 2); send(b, 0);
    wait_idle(100);
    check("t_tm", dut_tm_o, b[0]);
  endtask

  task automatic do_bad(input logic [7:0] b);
    exp_q.push_back(8'h3F);
    send(b, 0);
    wait_idle(100);
  endtask

  task automatic do_rst();
    int r0;
    r0 = rstn_low;
    exp_q.push_back(8'h4B);
    send(8'h72, 0);
    wait_idle(100);
    check("r_low_cycles", rstn_low - r0, 4);
    check("r_released", dut_rstn_o, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_dut_clk"}, dut_clk_o, 0);
    check({tag, "_dut_rstn"}, dut_rstn_o, 0);
    check({tag, "_se"}, dut_se_o, 0);
    check({tag, "_tm"}, dut_tm_o, 0);
    check({tag, "_si"}, dut_si_o, 0);
    check({tag, "_dut_in"}, dut_in_o, 0);
  endtask

  initial begin
    logic [7:0] b;
    int p0, n;
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rstn = 1'b1;
    @(posedge clk); #1;
    check("por_dut_rstn_release", dut_rstn_o, 1);
    repeat (2) @(negedge clk);

    do_load(8'hA5, 8'h03);
    do_get();
    do_get();
    do_run(16'd5);
    do_run(16'd0);
    do_in(8'h3C);
    do_out(8'h81);
    do_bad(8'h78);
    do_tm(8'h01);
    do_rst();
    do_run(16'h0103);

    for (int it = 0; it < 4; it++) begin
      do_load(8'($urandom), 8'($urandom));
      do_get();
      do_run(16'($urandom_range(1, 20)));
      do_in(8'($urandom));
      do_out(8'($urandom));
      b = 8'($urandom);
      if (b inside {8'h72, 8'h74, 8'h73, 8'h67, 8'h65, 8'h69, 8'h6F}) b = 8'h7A;
      do_bad(b);
      do_tm(8'($urandom));
    end

    // Async reset in the middle of a scan load, right after the 5th pulse rises.
    do_tm(8'h01);
    do_in(8'h5A);
    p0 = pulses; n = 0;
    send(8'h73, 2); send(8'hC3, 0);
    while (pulses - p0 < 5 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("mid_reset_pulses", pulses - p0, 5);
    rstn = 1'b0;
    #1;
    check_reset_outputs("mid");
    exp_q.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("mid_dut_rstn_release", dut_rstn_o, 1);
    repeat (2) @(negedge clk);
    do_out(8'hE7);
    do_out(8'($urandom));

    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
